// File: rtl/get_length_seq.sv
// rtl/get_length_seq.sv - multi-cycle chunked bit-length / trailing-zero finder
module get_length_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic             mode,
    input  logic [WIDTH-1:0] num_in,
    output logic [LEN_W-1:0] len_out,
    output logic             md_end,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   op_reg, op_n;
    logic               mode_reg, mode_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]   len_n;
    logic               md_end_n;

    logic [CHUNK-1:0]   chunk;
    logic [LEN_W-1:0]   base;
    logic [LEN_W-1:0]   lead_len;
    logic [LEN_W-1:0]   trail_cnt;
    logic               last_chunk;

    assign chunk      = op_reg[idx*CHUNK +: CHUNK];
    assign base       = LEN_W'(idx) * LEN_W'(CHUNK);
    assign last_chunk = mode_reg ? (idx == IDX_W'(NCHUNK - 1)) : (idx == '0);
    assign busy       = (state == SCAN);

    // Per-chunk priority encoders: highest set bit + 1, and lowest set bit.
    always_comb begin
        lead_len = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) lead_len = LEN_W'(i + 1);
        end
    end

    always_comb begin
        trail_cnt = LEN_W'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) trail_cnt = LEN_W'(i);
        end
    end

    always_comb begin
        state_n  = state;
        op_n     = op_reg;
        mode_n   = mode_reg;
        idx_n    = idx;
        len_n    = len_out;
        md_end_n = 1'b0;
        case (state)
            IDLE: begin
                if (md_start) begin
                    op_n    = num_in;
                    mode_n  = mode;
                    idx_n   = mode ? '0 : IDX_W'(NCHUNK - 1);
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (chunk != '0) begin
                    len_n    = base + (mode_reg ? trail_cnt : lead_len);
                    md_end_n = 1'b1;
                    state_n  = IDLE;
                end else if (last_chunk) begin
                    len_n    = mode_reg ? LEN_W'(WIDTH) : '0;
                    md_end_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    idx_n = mode_reg ? idx + 1'b1 : idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            op_reg   <= '0;
            mode_reg <= 1'b0;
            idx      <= '0;
            len_out  <= '0;
            md_end   <= 1'b0;
        end else begin
            state    <= state_n;
            op_reg   <= op_n;
            mode_reg <= mode_n;
            idx      <= idx_n;
            len_out  <= len_n;
            md_end   <= md_end_n;
        end
    end

endmodule

// File: tb/tb_get_length_seq.sv
// tb/tb_get_length_seq.sv - self-checking bench for get_length_seq (64/8/8 and 32/4/6)
module tb_get_length_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_a, start_b;
    logic        mode;
    logic [63:0] num;
    logic [7:0]  len_a;
    logic        md_end_a, busy_a;
    logic [5:0]  len_b;
    logic        md_end_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    get_length_seq #(.WIDTH(64), .CHUNK(8), .LEN_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .md_start(start_a), .mode(mode), .num_in(num),
        .len_out(len_a), .md_end(md_end_a), .busy(busy_a)
    );

    get_length_seq #(.WIDTH(32), .CHUNK(4), .LEN_W(6)) dut_b (
        .clk(clk), .rstn(rstn), .md_start(start_b), .mode(mode), .num_in(num[31:0]),
        .len_out(len_b), .md_end(md_end_b), .busy(busy_b)
    );

    typedef struct {
        bit          w;
        logic [63:0] n;
        bit          m;
        int          exp_len;
        int          exp_k;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic cur_end(input bit w);
        return w ? md_end_b : md_end_a;
    endfunction

    function automatic logic cur_busy(input bit w);
        return w ? busy_b : busy_a;
    endfunction

    function automatic logic [63:0] cur_len(input bit w);
        return w ? 64'(len_b) : 64'(len_a);
    endfunction

    // Whole-word view: find the highest / lowest set bit, then derive chunk count.
    function automatic void ref_model(input logic [63:0] n, input bit m, input int width,
                                      input int chunk, output int len, output int k);
        int nch = width / chunk;
        len = m ? width : 0;
        k   = nch;
        if (!m) begin
            for (int i = 0; i < width; i++)
                if (n[i]) begin len = i + 1; k = nch - i / chunk; end
        end else begin
            for (int i = width - 1; i >= 0; i--)
                if (n[i]) begin len = i; k = i / chunk + 1; end
        end
    endfunction

    // Drive a start request across edge E0 and check the DUT went busy.
    task automatic start_op(input bit w, input logic [63:0] n, input bit m, input string name);
        @(negedge clk);
        num  = n;
        mode = m;
        if (w) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check({name, " busy after start"}, 64'(cur_busy(w)), 64'd1);
        check({name, " md_end low after start"}, 64'(cur_end(w)), 64'd0);
    endtask

    task automatic wait_end(input bit w, input string name, output int k);
        k = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (cur_end(w)) begin k = c; break; end
        end
        if (k < 0) check({name, " timeout waiting md_end"}, 64'd0, 64'd1);
    endtask

    task automatic run_check(input bit w, input logic [63:0] n, input bit m,
                             input int exp_len, input int exp_k, input string name);
        int k;
        logic [63:0] held;
        start_op(w, n, m, name);
        wait_end(w, name, k);
        check({name, " scan edges"}, 64'(k), 64'(exp_k));
        check({name, " len_out"}, cur_len(w), 64'(exp_len));
        check({name, " busy low at md_end"}, 64'(cur_busy(w)), 64'd0);
        held = cur_len(w);
        @(posedge clk);
        #1;
        check({name, " single md_end pulse"}, 64'(cur_end(w)), 64'd0);
        check({name, " len_out held"}, cur_len(w), held);
    endtask

    vec_t vecs[$];

    initial begin
        int k, pulses, el, ek;
        logic [63:0] rn;
        bit rm;

        vecs.push_back('{0, 64'h9,                 0,  4, 8});
        vecs.push_back('{0, 64'h8000_0000_0000_0000, 0, 64, 1});
        vecs.push_back('{0, 64'h0,                 0,  0, 8});
        vecs.push_back('{0, 64'h0,                 1, 64, 8});
        vecs.push_back('{0, 64'h0000_0100_0000_0000, 1, 40, 6});
        vecs.push_back('{0, 64'h1,                 1,  0, 1});
        vecs.push_back('{0, 64'h8000_0000_0000_0000, 1, 63, 8});
        vecs.push_back('{0, 64'h1,                 0,  1, 8});
        vecs.push_back('{1, 64'h0001_0000,         0, 17, 4});
        vecs.push_back('{1, 64'h0001_0000,         1, 16, 5});
        vecs.push_back('{1, 64'h0,                 0,  0, 8});
        vecs.push_back('{1, 64'h0,                 1, 32, 8});
        vecs.push_back('{1, 64'h8000_0000,         0, 32, 1});

        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; num = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset len_a", 64'(len_a), 64'd0);
        check("reset md_end_a", 64'(md_end_a), 64'd0);
        check("reset busy_a", 64'(busy_a), 64'd0);
        check("reset len_b", 64'(len_b), 64'd0);
        check("reset busy_b", 64'(busy_b), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i])
            run_check(vecs[i].w, vecs[i].n, vecs[i].m, vecs[i].exp_len, vecs[i].exp_k,
                      $sformatf("vec%0d", i));

        // Mid-scan start/operand/mode changes must not disturb the result.
        start_op(0, 64'h9, 0, "midscan");
        fork
            begin
                repeat (2) @(negedge clk);
                start_a = 1'b1; num = 64'h1; mode = 1'b1;
                repeat (3) @(negedge clk);
                start_a = 1'b0; num = 64'hFFFF; mode = 1'b0;
            end
            wait_end(0, "midscan", k);
        join
        check("midscan scan edges", 64'(k), 64'd8);
        check("midscan len_out", 64'(len_a), 64'd4);

        // Back-to-back start in the md_end cycle.
        start_op(0, 64'hFF, 0, "b2b");
        wait_end(0, "b2b", k);
        check("b2b scan edges", 64'(k), 64'd8);
        check("b2b len_out", 64'(len_a), 64'd8);

        // Reset mid-scan discards the operation.
        start_op(0, 64'h9, 0, "rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst busy", 64'(busy_a), 64'd0);
        check("rst md_end", 64'(md_end_a), 64'd0);
        check("rst len_out", 64'(len_a), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (md_end_a) pulses++;
        end
        check("rst no pulse", 64'(pulses), 64'd0);
        run_check(0, 64'h10, 0, 5, 8, "after_rst");

        // Random sweep against the whole-word reference model.
        for (int i = 0; i < 80; i++) begin
            bit w;
            w  = i[0];
            rn = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rn = rn >> $urandom_range(0, 63);
                1: rn = rn << $urandom_range(0, 63);
                2: rn = 64'h1 << $urandom_range(0, 63);
                default: if ($urandom_range(0, 4) == 0) rn = '0;
            endcase
            rm = 1'($urandom_range(0, 1));
            if (w) ref_model(rn, rm, 32, 4, el, ek);
            else   ref_model(rn, rm, 64, 8, el, ek);
            run_check(w, rn, rm, el, ek, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
